sd_req_arbiter: RTL

- Serialises virtual-disk block requests from up to NUM_REQ drive controllers (FDD0, FDD1, HDD, ...) onto the single hps_io SD block channel.
- Guarantees at most one sd_rd/sd_wr bit is high at any time.
- Routes sd_ack and the write-data byte (sd_buff_din) to and from the granted client only.
- Sits between hps_io and the drive front ends in emu; runs on clk_sys.

---
 rtl/sd_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 34 +++
 rtl/sd_req_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and sizing helpers for the SD block-request arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;

    // Width of an index into n clients; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int GW = idx_width(NUM_REQ_DEF);

    // Width of a counter that must reach timeout-1.
    function automatic int cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first pending bit at or after ptr wins.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] index
);

    int           c;
    logic [W-1:0] cand;

    // Scan from the farthest offset down so the nearest pending client is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        c     = 0;
        cand  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            c = int'(ptr) + off;
            if (c >= N) c = c - N;
            cand = W'(c);
            if (pending[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Serialises per-drive SD block requests onto the single hps_io block channel.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter int          LBA_W   = 32,
    parameter int unsigned TIMEOUT = 24'd12_000_000
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NUM_REQ*LBA_W-1:0] req_lba,
    input  logic [NUM_REQ-1:0]       req_rd,
    input  logic [NUM_REQ-1:0]       req_wr,
    input  logic [NUM_REQ*8-1:0]     req_buff_din,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_err,
    output logic [LBA_W-1:0]         sd_lba,
    output logic [NUM_REQ-1:0]       sd_rd,
    output logic [NUM_REQ-1:0]       sd_wr,
    input  logic [NUM_REQ-1:0]       sd_ack,
    output logic [7:0]               sd_buff_din,
    output logic                     busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t         state;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      rr_ptr;
    logic [CW-1:0]      tmo_cnt;
    logic [NUM_REQ-1:0] pending;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic               tmo_hit;

    logic [LBA_W-1:0] lba_arr [NUM_REQ];
    logic [7:0]       din_arr [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The client after g gets first look next time; the serviced one drops to last.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + IW'(1);
    endfunction

    // Unpack the flat per-client buses into arrays indexed by client number.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lba_arr[i] = req_lba[i*LBA_W +: LBA_W];
            din_arr[i] = req_buff_din[i*8 +: 8];
        end
    end

    // A simultaneous read and write request counts as a read; the strobe choice handles that.
    assign pending = req_rd | req_wr;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign busy    = (state != IDLE);

    rr_pick #(
        .N (NUM_REQ),
        .W (IW)
    ) u_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    // Arbitration FSM: grant, issue strobe, wait for ack to fall, then release.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            tmo_cnt  <= '0;
            sd_lba   <= '0;
            sd_rd    <= '0;
            sd_wr    <= '0;
            req_done <= '0;
            req_err  <= '0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (pick_valid) begin
                        grant  <= pick_idx;
                        sd_lba <= lba_arr[pick_idx];
                        if (req_rd[pick_idx]) sd_rd <= onehot(pick_idx);
                        else                  sd_wr <= onehot(pick_idx);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_ack[grant]) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        state <= XFER;
                    end else if (tmo_hit) begin
                        sd_rd   <= '0;
                        sd_wr   <= '0;
                        req_err <= onehot(grant);
                        rr_ptr  <= next_ptr(grant);
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                XFER: begin
                    if (!sd_ack[grant]) begin
                        req_done <= onehot(grant);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= next_ptr(grant);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forward the hps_io ack to the granted client only while its transfer is live.
    always_comb begin
        req_ack = '0;
        if (state == ISSUE || state == XFER) req_ack[grant] = sd_ack[grant];
    end

    // Write byte follows the granted client while busy, otherwise the bus is parked at 0.
    always_comb begin
        sd_buff_din = busy ? din_arr[grant] : 8'h00;
    end

endmodule
